// File: rtl/proc_ctrl_pkg.sv
// Shared sequencer definitions: FSM state encoding and the opcode field layout
// used by both the sequencer and the datapath decoder.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_t;

  localparam int unsigned OPER_MSB = 31;
  localparam int unsigned OPER_LSB = 27;
  localparam logic [OPER_MSB-OPER_LSB:0] HALT_OP = 5'b11111;

  function automatic logic is_halt_op(input logic [OPER_MSB-OPER_LSB:0] op);
    return op == HALT_OP;
  endfunction

endpackage

// File: rtl/exec_timer.sv
// 4-bit loadable down-counter; o_done is high while the count sits at zero,
// which marks the final EXEC cycle.
module exec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: explicit fetch/decode/execute/writeback FSM driving
// the instruction ROM handshake, IR load and datapath strobes.
module instr_seq_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned EXEC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              halt_req,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd_en,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [INST_W-1:0] ir,
  output logic              ir_load,
  output logic              exec_en,
  output logic              wb_en,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_addr,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       inst_count
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_ir;
  logic [15:0]       r_inst_count;
  logic              r_rd_en;
  logic              r_ir_load;
  logic              r_exec_en;
  logic              r_wb_en;
  logic              r_busy;
  logic              r_halted;

  logic w_capture;
  logic w_is_halt;
  logic w_timer_load;
  logic w_timer_done;

  assign w_capture = (r_state == ST_FETCH) && imem_valid;
  assign w_is_halt = is_halt_op(r_ir[OPER_MSB:OPER_LSB]);

  exec_timer u_exec_timer (
    .clk        (clk),
    .rst        (sys_rst),
    .i_load     (w_timer_load),
    .i_load_val (EXEC_LOAD),
    .i_en       (r_state == ST_EXEC),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_FETCH;
      ST_FETCH:  if (imem_valid) w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_is_halt) begin
          w_next = ST_HALTED;
        end else begin
          w_timer_load = 1'b1;
          w_next       = ST_EXEC;
        end
      end
      ST_EXEC:   if (w_timer_done) w_next = ST_WB;
      ST_WB:     w_next = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (start) w_next = ST_FETCH;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is high exactly
  // while the FSM occupies the matching state, without a decode after the flop.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rd_en   <= 1'b0;
      r_ir_load <= 1'b0;
      r_exec_en <= 1'b0;
      r_wb_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_rd_en   <= (w_next == ST_FETCH);
      r_ir_load <= w_capture;
      r_exec_en <= (w_next == ST_EXEC);
      r_wb_en   <= (w_next == ST_WB);
      r_busy    <= (w_next == ST_FETCH) || (w_next == ST_DECODE) ||
                   (w_next == ST_EXEC)  || (w_next == ST_WB);
      r_halted  <= (w_next == ST_HALTED);
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_inst_count <= '0;
    end else begin
      if (w_capture) begin
        r_ir <= imem_rdata;
      end
      if ((r_state == ST_DECODE) && w_is_halt) begin
        r_pc         <= r_pc + 1'b1;
        r_inst_count <= r_inst_count + 16'd1;
      end else if (r_state == ST_WB) begin
        r_pc         <= jump_en ? jump_addr : r_pc + 1'b1;
        r_inst_count <= r_inst_count + 16'd1;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign imem_rd_en = r_rd_en;
  assign ir         = r_ir;
  assign ir_load    = r_ir_load;
  assign exec_en    = r_exec_en;
  assign wb_en      = r_wb_en;
  assign pc         = r_pc;
  assign busy       = r_busy;
  assign halted     = r_halted;
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed and randomized bench for instr_seq_ctrl; a per-instruction reference
// model tracks pc, ir and inst_count from the sequencing rules.
module tb_instr_seq_ctrl;

  localparam int unsigned EC = 4;
  localparam logic [5:0] S_IDLE   = 6'b000000;
  localparam logic [5:0] S_FETCH  = 6'b100010;
  localparam logic [5:0] S_DECODE = 6'b010010;
  localparam logic [5:0] S_EXEC   = 6'b001010;
  localparam logic [5:0] S_WB     = 6'b000110;
  localparam logic [5:0] S_HALTED = 6'b000001;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] ir;
  logic        ir_load;
  logic        exec_en;
  logic        wb_en;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] inst_count;

  logic [5:0] strb;
  assign strb = {imem_rd_en, ir_load, exec_en, wb_en, busy, halted};

  instr_seq_ctrl #(.PC_W(8), .INST_W(32), .EXEC_CYCLES(EC)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .halt_req   (halt_req),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ir         (ir),
    .ir_load    (ir_load),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [31:0] rom [256];
  logic [7:0]  m_pc  = '0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_ir  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [4:0]  op;
    logic [26:0] rest;
    op   = 5'($urandom_range(0, 30));
    rest = 27'($urandom);
    return {op, rest};
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},   pc, m_pc);
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_cnt"},  inst_count, m_cnt);
    chk({tag, "_ir"},   ir, m_ir);
  endtask

  task automatic restart();
    chk("restart_halted", strb, S_HALTED);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction starting in its first FETCH cycle; ends_halted tells
  // the caller whether the sequencer parked in HALTED afterwards.
  task automatic do_instr(input int k, input bit jmp, input logic [7:0] ja,
                          input bit hreq, input bit spur, input bit exjmp,
                          input bit rst_mid, output bit ends_halted);
    logic [31:0] w;
    w = rom[m_pc];
    ends_halted = 1'b0;
    for (int c = 0; c <= k; c++) begin
      chk("fetch_strb", strb, S_FETCH);
      chk_model("fetch");
      imem_valid = (c == k);
      imem_rdata = (c == k) ? w : $urandom;
      tick();
    end
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    m_ir = w;
    chk("decode_strb", strb, S_DECODE);
    chk_model("decode");
    if (w[31:27] == 5'h1f) begin
      tick();
      m_pc  = m_pc + 8'd1;
      m_cnt = m_cnt + 16'd1;
      chk("haltop_strb", strb, S_HALTED);
      chk_model("haltop");
      ends_halted = 1'b1;
      return;
    end
    tick();
    for (int e = 0; e < int'(EC); e++) begin
      chk("exec_strb", strb, S_EXEC);
      chk_model("exec");
      if (rst_mid && e == 1) begin
        sys_rst = 1'b1;
        #1;
        m_pc = '0; m_cnt = '0; m_ir = '0;
        chk("rst_strb", strb, S_IDLE);
        chk_model("rst");
        tick();
        tick();
        sys_rst = 1'b0;
        return;
      end
      if (hreq) halt_req = 1'b1;
      imem_valid = spur && (e == 0);
      imem_rdata = $urandom;
      if (exjmp && e == int'(EC) - 1) begin
        jump_en   = 1'b1;
        jump_addr = 8'($urandom);
      end
      tick();
    end
    imem_valid = 1'b0;
    chk("wb_strb", strb, S_WB);
    chk_model("wb");
    jump_en   = jmp;
    jump_addr = ja;
    tick();
    jump_en  = 1'b0;
    m_cnt = m_cnt + 16'd1;
    m_pc  = jmp ? ja : m_pc + 8'd1;
    chk_model("post_wb");
    if (hreq) begin
      chk("post_wb_halt", strb, S_HALTED);
      halt_req = 1'b0;
      ends_halted = 1'b1;
    end else begin
      chk("post_wb_fetch", strb, S_FETCH);
    end
  endtask

  initial begin
    bit h;
    for (int i = 0; i < 256; i++) rom[i] = rand_word();
    rom[0] = 32'h0800_0000;
    rom[1] = 32'h1000_0001;
    rom[2] = 32'h1800_0002;
    rom[3] = 32'hF800_0000;

    // Reset state
    #1 sys_rst = 1'b1;
    #2;
    chk("reset_strb", strb, S_IDLE);
    chk_model("reset");
    tick();
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_strb", strb, S_IDLE);
    end

    // Three plain instructions, 1-cycle ROM latency
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) do_instr(1, 0, 8'h00, 0, 0, 0, 0, h);
    chk("three_cnt", inst_count, 16'd3);

    // HALT opcode at pc=3; halt_req in HALTED is ignored
    do_instr(1, 0, 8'h00, 0, 0, 0, 0, h);
    halt_req = 1'b1;
    tick();
    tick();
    halt_req = 1'b0;
    chk("halted_hold", strb, S_HALTED);
    chk("halted_pc", pc, 32'h4);
    restart();

    // Redirect in WB honoured, pulse in EXEC ignored
    do_instr(1, 1, 8'h10, 0, 0, 0, 0, h);
    do_instr(1, 0, 8'h00, 0, 0, 1, 0, h);

    // PC wrap and halt_req held from EXEC
    do_instr(2, 1, 8'hFF, 0, 0, 0, 0, h);
    do_instr(1, 0, 8'h00, 0, 0, 0, 0, h);
    chk("wrap_pc", pc, 32'h0);
    do_instr(1, 0, 8'h00, 1, 0, 0, 0, h);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stay_halted", strb, S_HALTED);
    end
    restart();

    // Slow ROM plus a spurious valid during EXEC
    do_instr(5, 0, 8'h00, 0, 1, 0, 0, h);

    // Randomized instruction stream
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) rom[m_pc] = {5'h1f, 27'($urandom)};
      do_instr(int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0),
               8'($urandom), ($urandom_range(0, 5) == 0),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, h);
      if (h) restart();
    end

    // Asynchronous reset in the middle of EXEC
    if (rom[m_pc][31:27] == 5'h1f) rom[m_pc] = 32'h0800_0000;
    do_instr(1, 0, 8'h00, 0, 0, 0, 1, h);
    chk_model("after_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", strb, S_IDLE);
    end
    rom[0] = 32'h0800_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_instr(1, 0, 8'h00, 0, 0, 0, 0, h);
    chk("final_cnt", inst_count, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
